// File: rtl/dm_lsu.sv
// dm_lsu: word-organised data memory with an integrated load/store unit.
//
// One request at a time over a Req/Ready/Done handshake. The block decodes
// byte lane and access size, merges partial stores into the addressed word,
// extends load data, and rejects misaligned, out-of-range and illegal-op
// requests without touching memory.
//
// Parameters:
//   ADDR_W  - byte-address width (DEPTH*4 <= 2**ADDR_W)
//   DEPTH   - number of 32-bit words
//   LATENCY - cycles from accept edge to Done (1..15)
//
// Ports:
//   Clk     in   clock, all state on rising edge
//   Reset_n in   synchronous active-low reset
//   Req     in   request valid, accepted when Req && Ready at an edge
//   Ready   out  idle, can accept a request
//   We      in   1 = store, 0 = load
//   Op      in   000 word, 001 half u, 010 half s, 011 byte u, 100 byte s
//   Addr    in   byte address
//   WD      in   store data, right-aligned
//   RD      out  extended load data, held until the next Done
//   Done    out  one-cycle completion pulse
//   Err     out  access rejected (valid with Done)
//
// Optional feature macro: DM_CLEAR_EN. When defined, the block zeroes the
// whole memory one word per cycle after reset before becoming Ready.
module dm_lsu #(
  parameter int ADDR_W  = 13,
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req,
  output logic              Ready,
  input  logic              We,
  input  logic [2:0]        Op,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              Done,
  output logic              Err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  // Word-index limit held in ADDR_W-1 bits so DEPTH == 2**(ADDR_W-2) still fits.
  localparam logic [ADDR_W-2:0] DEPTH_V = (ADDR_W-1)'(DEPTH);

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HU = 3'b001;
  localparam logic [2:0] OP_HS = 3'b010;
  localparam logic [2:0] OP_BU = 3'b011;
  localparam logic [2:0] OP_BS = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  // Request is rejected for misalignment, out-of-range index or illegal op.
  function automatic logic acc_err(input logic [2:0] op, input logic [ADDR_W-1:0] addr);
    logic e;
    case (op)
      OP_W:         e = (addr[1:0] != 2'b00);
      OP_HU, OP_HS: e = addr[0];
      OP_BU, OP_BS: e = 1'b0;
      default:      e = 1'b1;
    endcase
    if ({1'b0, addr[ADDR_W-1:2]} >= DEPTH_V) begin
      e = 1'b1;
    end
    return e;
  endfunction

  // Extract the addressed byte/half and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] op,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_W:    r = w;
      OP_HU:   r = {16'h0000, h};
      OP_HS:   r = {{16{h[15]}}, h};
      OP_BU:   r = {24'h000000, b};
      OP_BS:   r = {{24{b[7]}}, b};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Byte enables of a store.
  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      OP_W:         be = 4'b1111;
      OP_HU, OP_HS: be = lane[1] ? 4'b1100 : 4'b0011;
      OP_BU, OP_BS: be = 4'b0001 << lane;
      default:      be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated so every enabled lane sees its slice.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] d;
    case (op)
      OP_HU, OP_HS: d = {2{wd[15:0]}};
      OP_BU, OP_BS: d = {4{wd[7:0]}};
      default:      d = wd;
    endcase
    return d;
  endfunction

  logic [31:0]      mem [DEPTH];

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      wd_q, wd_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      rd_q, rd_d;
  logic             commit_s;
  logic [3:0]       be_s;
  logic [31:0]      wdat_s;
`ifdef DM_CLEAR_EN
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
`endif

  assign Ready = ready_q;
  assign Done  = done_q;
  assign Err   = err_q;
  assign RD    = rd_q;

  assign be_s   = store_be(op_q, lane_q);
  assign wdat_s = store_data(op_q, wd_q);

  // Next-state, capture and output logic of the request FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    op_d     = op_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    wd_d     = wd_q;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rd_d     = rd_q;
    commit_s = 1'b0;
`ifdef DM_CLEAR_EN
    clr_idx_d = clr_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Req && ready_q) begin
          we_d   = We;
          op_d   = Op;
          idx_d  = Addr[IDX_W+1:2];
          lane_d = Addr[1:0];
          wd_d   = WD;
          cnt_d  = 4'd0;
          if (acc_err(Op, Addr)) begin
            // Rejected requests complete on the very next edge.
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rd_d    = 32'h0000_0000;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_M1) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          commit_s = we_q;
          if (!we_q) begin
            rd_d = load_ext(mem[idx_q], op_q, lane_q);
          end else begin
            rd_d = rd_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
`ifdef DM_CLEAR_EN
      ST_CLEAR: begin
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
`ifdef DM_CLEAR_EN
      state_q   <= ST_CLEAR;
      ready_q   <= 1'b0;
      clr_idx_q <= '0;
`else
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
`endif
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      op_q    <= 3'b000;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      wd_q    <= 32'h0000_0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 32'h0000_0000;
    end else begin
`ifdef DM_CLEAR_EN
      clr_idx_q <= clr_idx_d;
`endif
      state_q <= state_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Memory array: lane-masked store commit; reset edge drops any pending store.
  always_ff @(posedge Clk) begin
    if (Reset_n) begin
      if (commit_s) begin
        for (int i = 0; i < 4; i++) begin
          if (be_s[i]) begin
            mem[idx_q][8*i +: 8] <= wdat_s[8*i +: 8];
          end
        end
      end
`ifdef DM_CLEAR_EN
      if (state_q == ST_CLEAR) begin
        mem[clr_idx_q] <= 32'h0000_0000;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
module tb_dm_lsu;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: ADDR_W=13, DEPTH=2048, LATENCY=1
  // Instance 1: ADDR_W=14, DEPTH=2048, LATENCY=4
  logic [1:0]        rst_n = 2'b00;
  logic [1:0]        req   = 2'b00;
  logic [1:0]        we    = 2'b00;
  logic [1:0][2:0]   op    = '0;
  logic [1:0][13:0]  addr  = '0;
  logic [1:0][31:0]  wd    = '0;
  logic [1:0]        ready;
  logic [1:0]        done;
  logic [1:0]        err;
  logic [1:0][31:0]  rd;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  dm_lsu #(.ADDR_W(13), .DEPTH(2048), .LATENCY(1)) u_dut0 (
    .Clk(clk), .Reset_n(rst_n[0]), .Req(req[0]), .Ready(ready[0]), .We(we[0]),
    .Op(op[0]), .Addr(addr[0][12:0]), .WD(wd[0]), .RD(rd[0]), .Done(done[0]), .Err(err[0])
  );

  dm_lsu #(.ADDR_W(14), .DEPTH(2048), .LATENCY(4)) u_dut1 (
    .Clk(clk), .Reset_n(rst_n[1]), .Req(req[1]), .Ready(ready[1]), .We(we[1]),
    .Op(op[1]), .Addr(addr[1]), .WD(wd[1]), .RD(rd[1]), .Done(done[1]), .Err(err[1])
  );

  // One complete request on instance s; the expected result goes through the scoreboard.
  task automatic do_req(input int s, input logic w, input logic [2:0] o, input logic [13:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                        input string name);
    int   n;
    int   lat;
    exp_t e;
    lat = exp_err ? 1 : ((s == 0) ? 2 : 5);
    @(negedge clk);
    checks++;
    if (ready[s] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_idle got %b want 1", name, ready[s]);
    end
    req[s] = 1'b1; we[s] = w; op[s] = o; addr[s] = a; wd[s] = d;
    sb_q.push_back('{rd: exp_rd, err: exp_err, chk_rd: (!w || exp_err)});
    @(posedge clk);
    #1 req[s] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done[s] !== 1'b1 && n < 40);
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s done_latency got %0d want %0d", name, n, lat);
    end
    e = sb_q.pop_front();
    checks++;
    if (err[s] !== e.err) begin
      errors++;
      $display("FAIL %s err got %b want %b", name, err[s], e.err);
    end
    if (e.chk_rd) begin
      checks++;
      if (rd[s] !== e.rd) begin
        errors++;
        $display("FAIL %s rd got %h want %h", name, rd[s], e.rd);
      end
    end
    checks++;
    if (ready[s] !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_at_done got %b want 0", name, ready[s]);
    end
    @(negedge clk);
    checks++;
    if (ready[s] !== 1'b1 || done[s] !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done ready=%b done=%b want 1/0", name, ready[s], done[s]);
    end
  endtask

  task automatic test_reset();
    logic exp_ready;
    int   n;
`ifdef DM_CLEAR_EN
    exp_ready = 1'b0;
`else
    exp_ready = 1'b1;
`endif
    rst_n = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (ready[s] !== exp_ready || done[s] !== 1'b0 || err[s] !== 1'b0 || rd[s] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state%0d ready=%b done=%b err=%b rd=%h want %b/0/0/0",
                 s, ready[s], done[s], err[s], rd[s], exp_ready);
      end
    end
    rst_n = 2'b11;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready[0] !== 1'b1 && n < 3000);
    checks++;
`ifdef DM_CLEAR_EN
    if (n != 2048) begin
`else
    if (n != 1) begin
`endif
      errors++;
      $display("FAIL reset_ready_cycles got %0d", n);
    end
  endtask

`ifdef DM_CLEAR_EN
  task automatic test_clear();
    do_req(0, 1'b0, 3'b000, 14'h0000, 32'h0, 32'h0000_0000, 1'b0, "clear_w0");
    do_req(0, 1'b0, 3'b000, 14'h1FFC, 32'h0, 32'h0000_0000, 1'b0, "clear_wlast");
    do_req(1, 1'b0, 3'b000, 14'h0400, 32'h0, 32'h0000_0000, 1'b0, "clear_mid");
  endtask
`endif

  task automatic test_word();
    do_req(0, 1'b1, 3'b000, 14'h0010, 32'h1122_3344, 32'h0, 1'b0, "st_word");
    do_req(0, 1'b0, 3'b000, 14'h0010, 32'h0, 32'h1122_3344, 1'b0, "ld_word");
  endtask

  task automatic test_merge();
    do_req(0, 1'b1, 3'b000, 14'h0020, 32'h1122_3344, 32'h0, 1'b0, "mg_word");
    do_req(0, 1'b1, 3'b011, 14'h0021, 32'hFFFF_FFAA, 32'h0, 1'b0, "mg_byte");
    do_req(0, 1'b1, 3'b001, 14'h0022, 32'h5555_BEEF, 32'h0, 1'b0, "mg_half");
    do_req(0, 1'b0, 3'b000, 14'h0020, 32'h0, 32'hBEEF_AA44, 1'b0, "mg_load");
  endtask

  task automatic test_extend();
    do_req(0, 1'b1, 3'b000, 14'h0030, 32'h80F0_7F01, 32'h0, 1'b0, "ext_word");
    do_req(0, 1'b0, 3'b100, 14'h0033, 32'h0, 32'hFFFF_FF80, 1'b0, "ext_bs33");
    do_req(0, 1'b0, 3'b011, 14'h0033, 32'h0, 32'h0000_0080, 1'b0, "ext_bu33");
    do_req(0, 1'b0, 3'b010, 14'h0032, 32'h0, 32'hFFFF_80F0, 1'b0, "ext_hs32");
    do_req(0, 1'b0, 3'b001, 14'h0030, 32'h0, 32'h0000_7F01, 1'b0, "ext_hu30");
    do_req(0, 1'b0, 3'b100, 14'h0031, 32'h0, 32'h0000_007F, 1'b0, "ext_bs31");
    do_req(0, 1'b0, 3'b011, 14'h0032, 32'h0, 32'h0000_00F0, 1'b0, "ext_bu32");
    do_req(0, 1'b0, 3'b010, 14'h0030, 32'h0, 32'h0000_7F01, 1'b0, "ext_hs30");
  endtask

  task automatic test_errors();
    do_req(0, 1'b1, 3'b000, 14'h0022, 32'hDEAD_BEEF, 32'h0, 1'b1, "err_st_word22");
    do_req(0, 1'b0, 3'b000, 14'h0020, 32'h0, 32'hBEEF_AA44, 1'b0, "err_unchanged");
    do_req(0, 1'b0, 3'b001, 14'h0031, 32'h0, 32'h0000_0000, 1'b1, "err_ld_half31");
    do_req(0, 1'b0, 3'b111, 14'h0030, 32'h0, 32'h0000_0000, 1'b1, "err_op111");
    do_req(0, 1'b1, 3'b101, 14'h0030, 32'h1234_5678, 32'h0, 1'b1, "err_st_op101");
    do_req(0, 1'b0, 3'b000, 14'h0032, 32'h0, 32'h0000_0000, 1'b1, "err_ld_word32");
    do_req(0, 1'b0, 3'b000, 14'h0030, 32'h0, 32'h80F0_7F01, 1'b0, "err_30_kept");
  endtask

  task automatic test_range();
    do_req(1, 1'b1, 3'b000, 14'h1FFC, 32'hA5A5_5A5A, 32'h0, 1'b0, "rng_st_last");
    do_req(1, 1'b0, 3'b000, 14'h1FFC, 32'h0, 32'hA5A5_5A5A, 1'b0, "rng_ld_last");
    do_req(1, 1'b0, 3'b000, 14'h2000, 32'h0, 32'h0000_0000, 1'b1, "rng_ld_oob");
    do_req(1, 1'b1, 3'b011, 14'h2001, 32'h0000_00FF, 32'h0, 1'b1, "rng_st_oob");
  endtask

  task automatic test_back_to_back();
    int   prev;
    int   accepts;
    int   dones;
    int   n;
    exp_t e;
    do_req(1, 1'b1, 3'b000, 14'h0040, 32'hCAFE_F00D, 32'h0, 1'b0, "b2b_store");
    prev = -1; accepts = 0; dones = 0;
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; op[1] = 3'b000; addr[1] = 14'h0040;
    for (int i = 0; i < 40; i++) begin
      if (done[1] === 1'b1) begin
        dones++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious_done at cycle %0d got done want none", i);
        end else begin
          e = sb_q.pop_front();
          if (rd[1] !== e.rd || err[1] !== e.err) begin
            errors++;
            $display("FAIL b2b_data got %h/%b want %h/%b", rd[1], err[1], e.rd, e.err);
          end
        end
      end
      if (i == 39) begin
        req[1] = 1'b0;
      end else if (ready[1] === 1'b1) begin
        sb_q.push_back('{rd: 32'hCAFE_F00D, err: 1'b0, chk_rd: 1'b1});
        if (prev >= 0) begin
          checks++;
          if (i - prev != 6) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 6", i - prev);
          end
        end
        prev = i;
        accepts++;
      end
      @(negedge clk);
    end
    n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      if (done[1] === 1'b1) begin
        dones++;
        e = sb_q.pop_front();
        checks++;
        if (rd[1] !== e.rd || err[1] !== e.err) begin
          errors++;
          $display("FAIL b2b_data got %h/%b want %h/%b", rd[1], err[1], e.rd, e.err);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (accepts != 7 || dones != accepts || sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_counts accepts=%0d dones=%0d left=%0d want 7/7/0", accepts, dones, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid_store();
    do_req(1, 1'b1, 3'b000, 14'h0050, 32'h1234_5678, 32'h0, 1'b0, "rms_init");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; op[1] = 3'b000; addr[1] = 14'h0050; wd[1] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    checks++;
`ifdef DM_CLEAR_EN
    if (done[1] !== 1'b0 || rd[1] !== 32'h0) begin
`else
    if (ready[1] !== 1'b1 || done[1] !== 1'b0 || rd[1] !== 32'h0) begin
`endif
      errors++;
      $display("FAIL rms_reset ready=%b done=%b rd=%h want 1/0/0", ready[1], done[1], rd[1]);
    end
    rst_n[1] = 1'b1;
`ifdef DM_CLEAR_EN
    repeat (2050) @(negedge clk);
`else
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (done[1] !== 1'b0) begin
        errors++;
        $display("FAIL rms_no_done got done=%b want 0", done[1]);
      end
    end
    do_req(1, 1'b0, 3'b000, 14'h0050, 32'h0, 32'h1234_5678, 1'b0, "rms_unchanged");
`endif
  endtask

  initial begin
    test_reset();
`ifdef DM_CLEAR_EN
    test_clear();
`endif
    test_word();
    test_merge();
    test_extend();
    test_errors();
    test_range();
    test_back_to_back();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
